// File: rtl/wb_commit_stage_pkg.sv
// Shared CP0 addresses, exception codes, register bit positions and the WB instruction record.
// Used by the write-back/commit stage and its CP0 register block.
package wb_commit_stage_pkg;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exccode_e;

   // CP0 addresses are {rd[4:0], sel[2:0]}
   localparam logic [7:0] CP0_BADVADDR = 8'h40;
   localparam logic [7:0] CP0_COUNT    = 8'h48;
   localparam logic [7:0] CP0_COMPARE  = 8'h58;
   localparam logic [7:0] CP0_STATUS   = 8'h60;
   localparam logic [7:0] CP0_CAUSE    = 8'h68;
   localparam logic [7:0] CP0_EPC      = 8'h70;

   localparam int STATUS_BEV   = 22;
   localparam int STATUS_IM_LO = 8;
   localparam int STATUS_EXL   = 1;
   localparam int STATUS_IE    = 0;
   localparam int CAUSE_BD     = 31;
   localparam int CAUSE_TI     = 30;
   localparam int CAUSE_IP_LO  = 8;
   localparam int CAUSE_EXC_LO = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] result;
      logic [31:0] badvaddr;
      logic [3:0]  gr_we;
      logic [4:0]  dest;
      logic        exc;
      logic [4:0]  exccode;
      logic        bd;
      logic        eret;
      logic        cp0_wen;
      logic        cp0_ren;
      logic [7:0]  cp0_addr;
   } ws_inst_t;

   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/wb_cp0_regs.sv
// CP0 register set: BadVAddr, Count/Compare timer, Status, Cause, EPC, interrupt request.
// Latency: reads combinational, all updates at the next edge; hw_int sampled one cycle before int_req.
// Backpressure: none, commits are applied unconditionally in the cycle they are presented.
module wb_cp0_regs
   import wb_commit_stage_pkg::*;
#(
   parameter int HW_INT_NUM = 6,
   parameter int COUNT_DIV  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [HW_INT_NUM-1:0] hw_int_i,
   input  logic [7:0]            addr_i,
   input  logic [31:0]           wdata_i,
   input  logic                  wen_i,
   input  logic                  eret_i,
   input  logic                  exc_commit_i,
   input  logic [4:0]            exc_code_i,
   input  logic                  exc_bd_i,
   input  logic [31:0]           exc_pc_i,
   input  logic [31:0]           exc_badvaddr_i,
   output logic [31:0]           rdata_o,
   output logic [31:0]           epc_o,
   output logic                  int_req_o
);

   localparam int DIV_W = 3;

   logic [DIV_W-1:0] div_q, div_d;
   logic [31:0]      count_q, count_d, compare_q, compare_d;
   logic [31:0]      epc_q, epc_d, badvaddr_q, badvaddr_d;
   logic [7:0]       im_q, im_d;
   logic             exl_q, exl_d, ie_q, ie_d;
   logic             bd_q, bd_d, ti_q, ti_d;
   logic [1:0]       ip_sw_q, ip_sw_d;
   logic [4:0]       exccode_q, exccode_d;
   logic [5:0]       hw_q, hw_ext;
   logic [7:0]       ip;
   logic             tick;
   logic             unused_hw5;
   logic [31:0]      status_rd, cause_rd;

   assign hw_ext = 6'(hw_int_i);
   // IP7 belongs to the timer; hardware line 5 is shadowed by it
   assign ip         = {ti_q, hw_q[4:0], ip_sw_q};
   assign unused_hw5 = hw_q[5];
   assign int_req_o  = ie_q && !exl_q && |(ip & im_q);
   assign epc_o      = epc_q;

   always_comb begin
      status_rd                         = '0;
      status_rd[STATUS_BEV]             = 1'b1;
      status_rd[STATUS_IM_LO +: 8]      = im_q;
      status_rd[STATUS_EXL]             = exl_q;
      status_rd[STATUS_IE]              = ie_q;
      cause_rd                          = '0;
      cause_rd[CAUSE_BD]                = bd_q;
      cause_rd[CAUSE_TI]                = ti_q;
      cause_rd[CAUSE_IP_LO +: 8]        = ip;
      cause_rd[CAUSE_EXC_LO +: 5]       = exccode_q;
      case (addr_i)
         CP0_BADVADDR: rdata_o = badvaddr_q;
         CP0_COUNT:    rdata_o = count_q;
         CP0_COMPARE:  rdata_o = compare_q;
         CP0_STATUS:   rdata_o = status_rd;
         CP0_CAUSE:    rdata_o = cause_rd;
         CP0_EPC:      rdata_o = epc_q;
         default:      rdata_o = 32'h0;
      endcase
   end

   always_comb begin
      tick       = (div_q == DIV_W'(COUNT_DIV - 1));
      div_d      = tick ? '0 : div_q + 1'b1;
      count_d    = count_q + {31'b0, tick};
      compare_d  = compare_q;
      ti_d       = ti_q | (count_q == compare_q);
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_sw_d    = ip_sw_q;
      exccode_d  = exccode_q;
      if (exc_commit_i) begin
         epc_d     = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
         bd_d      = exc_bd_i;
         exccode_d = exc_code_i;
         exl_d     = 1'b1;
         if (is_addr_exc(exc_code_i)) badvaddr_d = exc_badvaddr_i;
      end else begin
         // Software writes take priority over the timer increment and the match
         if (wen_i) begin
            case (addr_i)
               CP0_COUNT:   count_d = wdata_i;
               CP0_COMPARE: begin
                  compare_d = wdata_i;
                  ti_d      = 1'b0;
               end
               CP0_STATUS: begin
                  im_d  = wdata_i[STATUS_IM_LO +: 8];
                  exl_d = wdata_i[STATUS_EXL];
                  ie_d  = wdata_i[STATUS_IE];
               end
               CP0_CAUSE:   ip_sw_d = wdata_i[CAUSE_IP_LO +: 2];
               CP0_EPC:     epc_d   = wdata_i;
               default: ;
            endcase
         end
         if (eret_i) exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q      <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         ip_sw_q    <= '0;
         exccode_q  <= '0;
         hw_q       <= '0;
      end else begin
         div_q      <= div_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         ip_sw_q    <= ip_sw_d;
         exccode_q  <= exccode_d;
         hw_q       <= hw_ext;
      end
   end

endmodule

// File: rtl/wb_commit_stage.sv
// Write-back/commit stage: register-file write, precise exception/interrupt/ERET commit and redirect.
// Latency: one cycle from the MEM handshake; rf write and flush are combinational from the WB register.
// Backpressure: never stalls (ws_allowin is constant 1); a flush squashes the incoming instruction.
module wb_commit_stage
   import wb_commit_stage_pkg::*;
#(
   parameter int          HW_INT_NUM = 6,
   parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
   parameter int          COUNT_DIV  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  ws_allowin,
   input  logic                  ms_to_ws_valid,
   input  logic [31:0]           ms_pc,
   input  logic [31:0]           ms_result,
   input  logic [31:0]           ms_badvaddr,
   input  logic [3:0]            ms_gr_we,
   input  logic [4:0]            ms_dest,
   input  logic                  ms_exc,
   input  logic [4:0]            ms_exccode,
   input  logic                  ms_bd,
   input  logic                  ms_eret,
   input  logic                  ms_cp0_wen,
   input  logic                  ms_cp0_ren,
   input  logic [7:0]            ms_cp0_addr,
   input  logic [HW_INT_NUM-1:0] hw_int,
   output logic [3:0]            rf_we,
   output logic [4:0]            rf_waddr,
   output logic [31:0]           rf_wdata,
   output logic                  flush,
   output logic [31:0]           flush_pc,
   output logic [31:0]           debug_wb_pc,
   output logic [3:0]            debug_wb_rf_wen,
   output logic [4:0]            debug_wb_rf_wnum,
   output logic [31:0]           debug_wb_rf_wdata
);

   ws_inst_t    ws_q, ws_d;
   logic        ws_valid_q, ws_valid_d;
   logic        int_req, take_exc, eret_commit;
   logic [31:0] cp0_rdata, cp0_epc;

   assign ws_allowin = 1'b1;

   always_comb begin
      ws_d = ws_q;
      if (ms_to_ws_valid && ws_allowin && !flush) begin
         ws_d = '{pc: ms_pc, result: ms_result, badvaddr: ms_badvaddr, gr_we: ms_gr_we,
                  dest: ms_dest, exc: ms_exc, exccode: ms_exccode, bd: ms_bd, eret: ms_eret,
                  cp0_wen: ms_cp0_wen, cp0_ren: ms_cp0_ren, cp0_addr: ms_cp0_addr};
      end
      ws_valid_d = flush ? 1'b0 : ms_to_ws_valid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ws_valid_q <= 1'b0;
         ws_q       <= '0;
      end else begin
         ws_valid_q <= ws_valid_d;
         ws_q       <= ws_d;
      end
   end

   // An interrupt rides on the WB instruction and pre-empts its own exception and ERET
   assign take_exc    = ws_valid_q && (int_req || ws_q.exc);
   assign eret_commit = ws_valid_q && ws_q.eret && !take_exc;

   always_comb begin
      flush    = take_exc || eret_commit;
      flush_pc = take_exc ? EXC_VECTOR : cp0_epc;
      rf_we    = (ws_valid_q && !take_exc) ? ws_q.gr_we : 4'h0;
      rf_waddr = ws_q.dest;
      rf_wdata = ws_q.cp0_ren ? cp0_rdata : ws_q.result;
   end

   assign debug_wb_pc       = ws_q.pc;
   assign debug_wb_rf_wen   = rf_we;
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

   wb_cp0_regs #(
      .HW_INT_NUM (HW_INT_NUM),
      .COUNT_DIV  (COUNT_DIV)
   ) u_cp0 (
      .clk            (clk),
      .reset          (reset),
      .hw_int_i       (hw_int),
      .addr_i         (ws_q.cp0_addr),
      .wdata_i        (ws_q.result),
      .wen_i          (ws_valid_q && ws_q.cp0_wen),
      .eret_i         (eret_commit),
      .exc_commit_i   (take_exc),
      .exc_code_i     (int_req ? EXC_INT : ws_q.exccode),
      .exc_bd_i       (ws_q.bd),
      .exc_pc_i       (ws_q.pc),
      .exc_badvaddr_i (ws_q.badvaddr),
      .rdata_o        (cp0_rdata),
      .epc_o          (cp0_epc),
      .int_req_o      (int_req)
   );

endmodule
